bus_snoop_responder: RTL and testbench

BUS_SNOOP_RESPONDER -- requirements
Module: bus_snoop_responder

---
 rtl/bus_snoop_responder.sv | 194 +++++++++++++++++++
 tb/tb_bus_snoop_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_snoop_responder.sv
// Purpose : answers snooped bus operations (READ / RFO / INVALIDATE) against one cache tag array:
//           looks the line up, reports NOHIT/HIT/HITM, downgrades the MESI state and writes back dirty lines.
// Latency : result strobe 3 cycles after the snoop is accepted; writeback beats follow from the next cycle.
// Backpressure: one snoop at a time (snoopReady only in IDLE, no queuing); writeback beats stall on wbReady.
// Ports   : clk/reset (sync, active-high); snoop request handshake (snoopValid/snoopReady/snoopOp/snoopAddress);
//           tag lookup request (lookupValid/Index/Tag) and its response one cycle later (lookupHit/Way/Mesi, lineData);
//           MESI update strobe (mesiWrite/mesiWay/mesiValue); snoop result strobe (resultValid/snoopResult);
//           writeback beat stream (wbValid/wbReady/wbData/wbLast), lineSize/busWidth beats, lowest beat first.
module bus_snoop_responder #(
  parameter int indexBits = 14,
  parameter int tagBits   = 12,
  parameter int lineSize  = 512,
  parameter int ways      = 8,
  parameter int busWidth  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          snoopValid,
  output logic                          snoopReady,
  input  logic [1:0]                    snoopOp,
  input  logic [tagBits+indexBits-1:0]  snoopAddress,
  output logic                          lookupValid,
  output logic [indexBits-1:0]          lookupIndex,
  output logic [tagBits-1:0]            lookupTag,
  input  logic                          lookupHit,
  input  logic [$clog2(ways)-1:0]       lookupWay,
  input  logic [3:0]                    lookupMesi,
  input  logic [lineSize-1:0]           lineData,
  output logic                          mesiWrite,
  output logic [$clog2(ways)-1:0]       mesiWay,
  output logic [3:0]                    mesiValue,
  output logic                          resultValid,
  output logic [1:0]                    snoopResult,
  output logic                          wbValid,
  input  logic                          wbReady,
  output logic [busWidth-1:0]           wbData,
  output logic                          wbLast
);

  localparam int BEATS  = lineSize / busWidth;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RFO  = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;

  localparam logic [1:0] RES_NOHIT = 2'b00;
  localparam logic [1:0] RES_HIT   = 2'b01;
  localparam logic [1:0] RES_HITM  = 2'b10;

  localparam logic [3:0] MESI_M = 4'b1000;
  localparam logic [3:0] MESI_E = 4'b0100;
  localparam logic [3:0] MESI_S = 4'b0010;
  localparam logic [3:0] MESI_I = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CAPTURE,
    S_REPORT,
    S_WRITEBACK
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [1:0]           op_q;
  logic [lineSize-1:0]  line_q;
  logic [BEAT_W-1:0]    beat_q;

  logic                 eff_hit;
  logic [1:0]           dec_result;
  logic [3:0]           dec_new;
  logic                 dec_write;

  // Ready is a pure decode of the state register.
  assign snoopReady = (state_q == S_IDLE);

  // The line register shifts down one beat per handshake, so the current beat is always the low slice.
  assign wbData = line_q[busWidth-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (snoopValid) state_d = S_LOOKUP;
      S_LOOKUP:    state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_REPORT;
      S_REPORT:    state_d = (snoopResult == RES_HITM) ? S_WRITEBACK : S_IDLE;
      S_WRITEBACK: if (wbReady && wbLast) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Decode of the lookup response, consumed only in CAPTURE. A hit with a non-one-hot or Invalid
  // state is treated as a miss, so a corrupt tag entry never produces a response or an update.
  always_comb begin
    eff_hit    = lookupHit && ((lookupMesi == MESI_M) || (lookupMesi == MESI_E) ||
                               (lookupMesi == MESI_S));
    dec_result = RES_NOHIT;
    dec_new    = lookupMesi;
    dec_write  = 1'b0;
    if (eff_hit) begin
      case (op_q)
        OP_READ: begin
          dec_new    = MESI_S;
          dec_result = (lookupMesi == MESI_M) ? RES_HITM : RES_HIT;
        end
        OP_RFO, OP_INV: begin
          dec_new    = MESI_I;
          dec_result = (lookupMesi == MESI_M) ? RES_HITM : RES_HIT;
        end
        default: begin
          dec_new    = lookupMesi;
          dec_result = RES_NOHIT;
        end
      endcase
      dec_write = (dec_result != RES_NOHIT) && (dec_new != lookupMesi);
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      lookupValid <= 1'b0;
      lookupIndex <= '0;
      lookupTag   <= '0;
      mesiWrite   <= 1'b0;
      mesiWay     <= '0;
      mesiValue   <= '0;
      resultValid <= 1'b0;
      snoopResult <= '0;
      wbValid     <= 1'b0;
      wbLast      <= 1'b0;
    end else begin
      lookupValid <= 1'b0;
      resultValid <= 1'b0;
      mesiWrite   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (snoopValid) begin
            op_q        <= snoopOp;
            lookupTag   <= snoopAddress[tagBits+indexBits-1:indexBits];
            lookupIndex <= snoopAddress[indexBits-1:0];
            lookupValid <= 1'b1;
          end
        end
        S_CAPTURE: begin
          resultValid <= 1'b1;
          snoopResult <= dec_result;
          mesiWrite   <= dec_write;
          mesiWay     <= lookupWay;
          mesiValue   <= dec_write ? dec_new : 4'b0000;
          // Only dirty lines are kept; clean ones leave wbData at zero.
          line_q      <= (dec_result == RES_HITM) ? lineData : '0;
        end
        S_REPORT: begin
          if (snoopResult == RES_HITM) begin
            wbValid <= 1'b1;
            wbLast  <= (BEATS == 1);
            beat_q  <= '0;
          end
        end
        S_WRITEBACK: begin
          if (wbReady) begin
            if (wbLast) begin
              wbValid <= 1'b0;
              wbLast  <= 1'b0;
              beat_q  <= '0;
              line_q  <= '0;
            end else begin
              beat_q  <= beat_q + BEAT_W'(1);
              line_q  <= line_q >> busWidth;
              wbLast  <= (int'(beat_q) + 2 == BEATS);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_snoop_responder.sv
module tb_bus_snoop_responder;

  localparam int IB = 14;
  localparam int TGB = 12;
  localparam int LS = 512;
  localparam int BW = 64;
  localparam int NB = LS / BW;

  logic            clk = 1'b0;
  logic            reset;
  logic            snoopValid;
  logic            snoopReady;
  logic [1:0]      snoopOp;
  logic [TGB+IB-1:0] snoopAddress;
  logic            lookupValid;
  logic [IB-1:0]   lookupIndex;
  logic [TGB-1:0]  lookupTag;
  logic            lookupHit;
  logic [2:0]      lookupWay;
  logic [3:0]      lookupMesi;
  logic [LS-1:0]   lineData;
  logic            mesiWrite;
  logic [2:0]      mesiWay;
  logic [3:0]      mesiValue;
  logic            resultValid;
  logic [1:0]      snoopResult;
  logic            wbValid;
  logic            wbReady;
  logic [BW-1:0]   wbData;
  logic            wbLast;

  always #5 clk = ~clk;

  bus_snoop_responder dut (
    .clk(clk), .reset(reset),
    .snoopValid(snoopValid), .snoopReady(snoopReady), .snoopOp(snoopOp), .snoopAddress(snoopAddress),
    .lookupValid(lookupValid), .lookupIndex(lookupIndex), .lookupTag(lookupTag),
    .lookupHit(lookupHit), .lookupWay(lookupWay), .lookupMesi(lookupMesi), .lineData(lineData),
    .mesiWrite(mesiWrite), .mesiWay(mesiWay), .mesiValue(mesiValue),
    .resultValid(resultValid), .snoopResult(snoopResult),
    .wbValid(wbValid), .wbReady(wbReady), .wbData(wbData), .wbLast(wbLast)
  );

  // Tag array stand-in: the response is only meaningful in the cycle after lookupValid.
  logic            lv_d = 1'b0;
  logic            lk_hit;
  logic [2:0]      lk_way;
  logic [3:0]      lk_mesi;
  logic [LS-1:0]   lk_line;
  always @(posedge clk) lv_d <= lookupValid;
  assign lookupHit  = lv_d & lk_hit;
  assign lookupWay  = lv_d ? lk_way : 3'd0;
  assign lookupMesi = lv_d ? lk_mesi : 4'b0000;
  assign lineData   = lv_d ? lk_line : '0;

  // Every output other than snoopReady, for the all-zero checks.
  wire [103:0] others = {lookupValid, lookupIndex, lookupTag, mesiWrite, mesiWay, mesiValue,
                         resultValid, snoopResult, wbValid, wbData, wbLast};

  typedef struct {
    logic [1:0] res;
    logic       wr;
    logic [3:0] val;
    logic [2:0] way;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] beat_q[$];
  int total = 0;
  int bad = 0;

  function automatic exp_t model(input logic [1:0] op, input logic hit, input logic [3:0] mesi,
                                 input logic [2:0] way);
    exp_t e;
    logic [3:0] nxt;
    e.res = 2'b00; e.wr = 1'b0; e.val = 4'b0000; e.way = way;
    if (hit && (mesi == 4'b1000 || mesi == 4'b0100 || mesi == 4'b0010) && op != 2'b11) begin
      nxt   = (op == 2'b00) ? 4'b0010 : 4'b0001;
      e.res = (mesi == 4'b1000) ? 2'b10 : 2'b01;
      e.wr  = (nxt != mesi);
      e.val = nxt;
    end
    return e;
  endfunction

  function automatic logic [LS-1:0] byte_pattern();
    logic [LS-1:0] l;
    for (int i = 0; i < LS / 8; i++) l[i*8 +: 8] = 8'(i + 1);
    return l;
  endfunction

  // Presents one snoop (accepted at the next edge) and records what the bench expects from it.
  task automatic start_snoop(input logic [1:0] op, input logic [TGB+IB-1:0] addr, input logic hit,
                             input logic [2:0] way, input logic [3:0] mesi, input logic [LS-1:0] line);
    exp_t e;
    lk_hit = hit; lk_way = way; lk_mesi = mesi; lk_line = line;
    e = model(op, hit, mesi, way);
    exp_q.push_back(e);
    if (e.res == 2'b10)
      for (int k = 0; k < NB; k++) beat_q.push_back(line[k*BW +: BW]);
    snoopOp = op; snoopAddress = addr; snoopValid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (snoopReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", snoopReady); end
    total++; if (others !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", others); end
  endtask

  task automatic test_read_hit();
    logic [TGB+IB-1:0] addr;
    exp_t e;
    bit saw_wb;
    saw_wb = 1'b0;
    wbReady = 1'b1;
    addr = {12'hABC, 14'h1234};
    start_snoop(2'b00, addr, 1'b1, 3'd5, 4'b0100, {16{$urandom}});
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        snoopValid = 1'b0;
        total++; if (lookupValid !== 1'b1) begin bad++; $display("FAIL read_lookup_valid got=%b exp=1", lookupValid); end
        total++; if ({lookupTag, lookupIndex} !== addr) begin bad++; $display("FAIL read_lookup_addr got=%h exp=%h", {lookupTag, lookupIndex}, addr); end
      end
      if (c == 2) begin
        total++; if (lookupValid !== 1'b0) begin bad++; $display("FAIL read_lookup_pulse got=%b exp=0", lookupValid); end
      end
      if (resultValid) begin
        total++; if (c != 3) begin bad++; $display("FAIL read_result_cycle got=%0d exp=3", c); end
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL read_result_extra got=1 exp=0");
        end else begin
          e = exp_q.pop_front();
          total++; if (snoopResult !== e.res) begin bad++; $display("FAIL read_result got=%b exp=%b", snoopResult, e.res); end
          total++; if (mesiWrite !== e.wr) begin bad++; $display("FAIL read_mesi_write got=%b exp=%b", mesiWrite, e.wr); end
          total++; if ({mesiValue, mesiWay} !== {e.val, e.way}) begin bad++; $display("FAIL read_mesi_value got=%b/%0d exp=%b/%0d", mesiValue, mesiWay, e.val, e.way); end
        end
      end
      if (wbValid) saw_wb = 1'b1;
      if (c == 4) begin
        total++; if (snoopReady !== 1'b1) begin bad++; $display("FAIL read_ready_t4 got=%b exp=1", snoopReady); end
      end
    end
    total++; if (saw_wb) begin bad++; $display("FAIL read_no_wb got=1 exp=0"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL read_result_missing got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_writeback(input bit stall);
    exp_t e;
    int beats;
    int stall_cnt;
    beats = 0; stall_cnt = 0;
    wbReady = 1'b1;
    start_snoop(2'b01, {12'h055, 14'h0AAA}, 1'b1, 3'd6, 4'b1000, byte_pattern());
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) snoopValid = 1'b0;
      wbReady = !(stall && beats == 2 && stall_cnt < 3);
      if (resultValid) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL wb_result_extra got=1 exp=0");
        end else begin
          e = exp_q.pop_front();
          total++; if (snoopResult !== e.res) begin bad++; $display("FAIL wb_result got=%b exp=%b", snoopResult, e.res); end
          total++; if ({mesiWrite, mesiValue, mesiWay} !== {e.wr, e.val, e.way}) begin bad++; $display("FAIL wb_mesi got=%b/%b/%0d exp=%b/%b/%0d", mesiWrite, mesiValue, mesiWay, e.wr, e.val, e.way); end
        end
      end
      if (wbValid && !wbReady) begin
        stall_cnt++;
        total++; if (beat_q.size() == 0 || wbData !== beat_q[0] || wbLast !== 1'b0) begin bad++; $display("FAIL wb_hold got=%h/%b exp=beat%0d held, last=0", wbData, wbLast, beats); end
      end
      if (wbValid && wbReady) begin
        if (beat_q.size() == 0) begin
          total++; bad++; $display("FAIL wb_extra_beat got=%h exp=none", wbData);
        end else begin
          total++; if (wbData !== beat_q[0]) begin bad++; $display("FAIL wb_data beat%0d got=%h exp=%h", beats, wbData, beat_q[0]); end
          void'(beat_q.pop_front());
          total++; if (wbLast !== (beat_q.size() == 0)) begin bad++; $display("FAIL wb_last beat%0d got=%b exp=%b", beats, wbLast, beat_q.size() == 0); end
        end
        beats++;
        if (beats == NB) break;
      end
    end
    @(posedge clk); #1;
    total++; if (beats != NB) begin bad++; $display("FAIL wb_beat_count got=%0d exp=%0d", beats, NB); end
    total++; if (stall_cnt != (stall ? 3 : 0)) begin bad++; $display("FAIL wb_stall_count got=%0d exp=%0d", stall_cnt, stall ? 3 : 0); end
    total++; if ({snoopReady, wbValid} !== 2'b10) begin bad++; $display("FAIL wb_idle_after got=%b exp=10", {snoopReady, wbValid}); end
    exp_q.delete(); beat_q.delete();
  endtask

  task automatic test_nohit();
    logic [1:0] ops   [6] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
    logic       hits  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] mesis [6] = '{4'b0010, 4'b0001, 4'b0110, 4'b1000, 4'b1000, 4'b0100};
    exp_t e;
    wbReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_snoop(ops[i], 26'($urandom), hits[i], 3'(i), mesis[i], {16{$urandom}});
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        if (c == 1) snoopValid = 1'b0;
        if (c == 3) begin
          total++; if (resultValid !== 1'b1) begin bad++; $display("FAIL case%0d_result_valid got=%b exp=1", i, resultValid); end
          if (resultValid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++; if (snoopResult !== e.res) begin bad++; $display("FAIL case%0d_result got=%b exp=%b", i, snoopResult, e.res); end
            total++; if (mesiWrite !== e.wr) begin bad++; $display("FAIL case%0d_mesi_write got=%b exp=%b", i, mesiWrite, e.wr); end
            if (e.wr) begin
              total++; if (mesiValue !== e.val) begin bad++; $display("FAIL case%0d_mesi_value got=%b exp=%b", i, mesiValue, e.val); end
            end
          end
        end
        if (c == 4) begin
          total++; if ({snoopReady, wbValid} !== 2'b10) begin bad++; $display("FAIL case%0d_idle got=%b exp=10", i, {snoopReady, wbValid}); end
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_wb();
    exp_t e;
    int beats;
    bit hit4;
    beats = 0; hit4 = 1'b0;
    wbReady = 1'b1;
    start_snoop(2'b01, {12'h0F0, 14'h0101}, 1'b1, 3'd2, 4'b1000, {16{$urandom}});
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) snoopValid = 1'b0;
      if (resultValid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++; if (snoopResult !== e.res) begin bad++; $display("FAIL rst_wb_result got=%b exp=%b", snoopResult, e.res); end
      end
      if (wbValid) begin
        if (beats == 4) begin
          hit4 = 1'b1;
          reset = 1'b1;
          break;
        end
        total++; if (beat_q.size() == 0 || wbData !== beat_q[0]) begin bad++; $display("FAIL rst_wb_data beat%0d got=%h", beats, wbData); end
        if (beat_q.size() != 0) void'(beat_q.pop_front());
        beats++;
      end
    end
    total++; if (!hit4) begin bad++; $display("FAIL rst_wb_reach_beat4 got=%0d exp=4", beats); end
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (snoopReady !== 1'b1) begin bad++; $display("FAIL rst_wb_ready got=%b exp=1", snoopReady); end
    total++; if (others !== '0) begin bad++; $display("FAIL rst_wb_outputs got=%h exp=0", others); end
    exp_q.delete(); beat_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if ({wbValid, mesiWrite, resultValid} !== 3'b000) begin bad++; $display("FAIL rst_wb_quiet got=%b exp=000", {wbValid, mesiWrite, resultValid}); end
    end
    start_snoop(2'b00, {12'h123, 14'h0321}, 1'b1, 3'd1, 4'b0100, {16{$urandom}});
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) snoopValid = 1'b0;
      if (c == 3) begin
        total++; if (resultValid !== 1'b1 || exp_q.size() == 0) begin bad++; $display("FAIL rst_wb_new_snoop got=%b exp=1", resultValid); end
        else begin
          e = exp_q.pop_front();
          total++; if ({snoopResult, mesiWrite, mesiValue} !== {e.res, e.wr, e.val}) begin bad++; $display("FAIL rst_wb_new_result got=%b exp=%b", {snoopResult, mesiWrite, mesiValue}, {e.res, e.wr, e.val}); end
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lv_cnt;
    int res_cnt;
    bit prev_lv;
    lv_cnt = 0; res_cnt = 0; prev_lv = 1'b0;
    wbReady = 1'b1;
    start_snoop(2'b00, {12'h777, 14'h0777}, 1'b1, 3'd3, 4'b0010, {16{$urandom}});
    for (int i = 0; i < 4; i++) exp_q.push_back(model(2'b00, 1'b1, 4'b0010, 3'd3));
    // snoopValid stays high for 20 edges; a 4-cycle snoop can be accepted only at edges 1,5,9,13,17.
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (lookupValid) begin
        lv_cnt++;
        total++; if (prev_lv) begin bad++; $display("FAIL b2b_lookup_double at cycle %0d got=1 exp=0", c); end
      end
      prev_lv = lookupValid;
      if (resultValid) begin
        res_cnt++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++; if ({snoopResult, mesiWrite} !== {e.res, e.wr}) begin bad++; $display("FAIL b2b_result got=%b exp=%b", {snoopResult, mesiWrite}, {e.res, e.wr}); end
        end
      end
    end
    snoopValid = 1'b0;
    total++; if (lv_cnt != 5) begin bad++; $display("FAIL b2b_lookup_count got=%0d exp=5", lv_cnt); end
    total++; if (res_cnt != 5) begin bad++; $display("FAIL b2b_result_count got=%0d exp=5", res_cnt); end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; snoopValid = 1'b0; snoopOp = 2'b00; snoopAddress = '0; wbReady = 1'b0;
    lk_hit = 1'b0; lk_way = 3'd0; lk_mesi = 4'b0000; lk_line = '0;
    test_reset();
    test_read_hit();
    test_writeback(1'b0);
    test_writeback(1'b1);
    test_nohit();
    test_reset_mid_wb();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
